// File: rtl/version_store.sv
// Multi-version data store feeding the priority router: each write lands in the slot
// named by its version; a full store drains readers, then folds the newest value into slot 0.
module version_store #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    VERSION_WIDTH = 4,
  parameter int                    VERSION_NUM   = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA     = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wrValid,
  input  logic [DATA_WIDTH-1:0]                wrData,
  output logic                                 wrReady,
  output logic                                 wrAck,
  output logic [VERSION_WIDTH-1:0]             wrVersion,
  input  logic                                 readersBusy,
  output logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
  output logic [DATA_WIDTH*VERSION_NUM-1:0]    dataBus,
  output logic [VERSION_WIDTH-1:0]             latestVersion,
  output logic                                 collapsing
);

  typedef enum logic [1:0] {
    ACCEPT   = 2'd0,
    DRAIN    = 2'd1,
    COLLAPSE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [DATA_WIDTH-1:0]    r_data [VERSION_NUM];
  logic [VERSION_WIDTH-1:0] r_ver  [VERSION_NUM];
  logic [VERSION_WIDTH-1:0] r_latest;
  logic                     r_wr_ack;
  logic [VERSION_WIDTH-1:0] r_wr_version;

  logic                     w_accept;
  logic [VERSION_WIDTH-1:0] w_n;
  logic                     w_fills;
  logic [DATA_WIDTH-1:0]    w_latest_data;

  assign w_accept = wrValid && (r_state == ACCEPT);
  assign w_n      = r_latest + VERSION_WIDTH'(1);
  assign w_fills  = (w_n == VERSION_WIDTH'(VERSION_NUM - 1));

  // Newest stored word, folded into the base slot during COLLAPSE.
  always_comb begin
    w_latest_data = r_data[0];
    for (int i = 1; i < VERSION_NUM; i++) begin
      if (r_latest == VERSION_WIDTH'(i)) w_latest_data = r_data[i];
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACCEPT:   if (w_accept && w_fills) w_next_state = DRAIN;
      DRAIN:    if (!readersBusy)        w_next_state = COLLAPSE;
      COLLAPSE:                          w_next_state = ACCEPT;
      default:                           w_next_state = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACCEPT;
      r_latest     <= '0;
      r_wr_ack     <= 1'b0;
      r_wr_version <= '0;
      for (int i = 0; i < VERSION_NUM; i++) begin
        r_data[i] <= (i == 0) ? INIT_DATA : '0;
        r_ver[i]  <= '0;
      end
    end else begin
      r_state  <= w_next_state;
      r_wr_ack <= w_accept;
      if (w_accept) begin
        r_latest     <= w_n;
        r_wr_version <= w_n;
        for (int i = 1; i < VERSION_NUM; i++) begin
          if (w_n == VERSION_WIDTH'(i)) begin
            r_data[i] <= wrData;
            r_ver[i]  <= w_n;
          end
        end
      end
      // Slot 0 version stays 0; upper slots are emptied, their data left stale.
      if (r_state == COLLAPSE) begin
        r_data[0] <= w_latest_data;
        r_latest  <= '0;
        for (int i = 1; i < VERSION_NUM; i++) r_ver[i] <= '0;
      end
    end
  end

  always_comb begin
    versions = '0;
    dataBus  = '0;
    for (int i = 0; i < VERSION_NUM; i++) begin
      versions[i*VERSION_WIDTH +: VERSION_WIDTH] = r_ver[i];
      dataBus[i*DATA_WIDTH +: DATA_WIDTH]        = r_data[i];
    end
  end

  assign wrReady       = (r_state == ACCEPT);
  assign collapsing    = (r_state != ACCEPT);
  assign wrAck         = r_wr_ack;
  assign wrVersion     = r_wr_version;
  assign latestVersion = r_latest;

endmodule

// File: doc/version_store.md
Name: version_store

Overview:
- Multi-version data store that sits directly upstream of the priority router.
- Each accepted write is assigned the next version number. The data is stored in the slot whose index equals that version number.
- The store exposes flat version and data buses in the exact layout the router consumes: slot i version at bits [i*VERSION_WIDTH +: VERSION_WIDTH], slot i data at [i*DATA_WIDTH +: DATA_WIDTH].
- When all slots are used, the store waits for readers to quiesce. It then collapses the newest version into base slot 0 and reopens for writes.

Parameters:
- DATA_WIDTH, 32, width of one stored data word.
- VERSION_WIDTH, 4, width of a version number. Must satisfy VERSION_NUM < 2**VERSION_WIDTH, so readVersion = latestVersion+1 always fits.
- VERSION_NUM, 4, number of slots including base slot 0.
- INIT_DATA, 0, slot 0 data after reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wrValid  input  1  write request.
- wrData  input  DATA_WIDTH  data to store.
- wrReady  output  1  store can accept a write this cycle.
- wrAck  output  1  one-cycle pulse, cycle after acceptance.
- wrVersion  output  VERSION_WIDTH  version assigned to the last accepted write; valid while wrAck is high.
- readersBusy  input  1  at least one router read is outstanding; blocks collapse.
- versions  output  VERSION_WIDTH*VERSION_NUM  flat per-slot versions to the router.
- dataBus  output  DATA_WIDTH*VERSION_NUM  flat per-slot data to the router.
- latestVersion  output  VERSION_WIDTH  newest valid version; 0 means base only.
- collapsing  output  1  high in DRAIN and COLLAPSE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, and has priority over everything, including mid-DRAIN and mid-COLLAPSE.
- Values on reset:
  - slot 0 data = INIT_DATA; all other slot data = 0.
  - all version fields = 0.
  - latestVersion = 0; wrAck = 0; wrVersion = 0.
  - state = ACCEPT.
- Empty slot encoding: version field 0 means empty. An empty slot is never selected by the router, because the router requires version > 0 to beat its default. Slot 0's version field is constant 0.
- States:
  - ACCEPT:
    - wrReady = 1.
    - Accept when wrValid && wrReady. With n = latestVersion+1 at the clock edge: slot n data ← wrData, slot n version ← n, latestVersion ← n, wrVersion ← n, wrAck ← 1.
    - If n == VERSION_NUM-1, next state is DRAIN; otherwise stay in ACCEPT.
    - readersBusy is ignored in ACCEPT.
  - DRAIN:
    - wrReady = 0; wrValid is ignored (the producer holds it).
    - Buses are unchanged.
    - When readersBusy is sampled 0, next state is COLLAPSE.
  - COLLAPSE (exactly one cycle):
    - wrReady = 0.
    - slot 0 data ← slot latestVersion data.
    - slot 1..VERSION_NUM-1 version fields ← 0; their data is unchanged (don't-care).
    - latestVersion ← 0; next state is ACCEPT.
- Timing:
  - wrReady is a function of the registered state only; there is no combinational path from wrValid.
  - All outputs except wrReady are registered. Bus and latestVersion changes are visible the cycle after the accepting or collapsing edge.
  - Write-to-visibility latency = 1 cycle. The router sees version n once readVersion > n.
  - Back-to-back writes are accepted one per cycle while in ACCEPT.
  - wrAck is low in every cycle that does not follow an acceptance.
- VERSION_NUM == 2: every write fills the store and triggers DRAIN→COLLAPSE. Throughput is one write per 3 cycles minimum.

Test Plan (VERSION_NUM=4, VERSION_WIDTH=4, DATA_WIDTH=32, INIT_DATA=32'h0):
1. Reset → versions=16'h0000, dataBus slot0=0, latestVersion=0, wrReady=1, wrAck=0, collapsing=0.
2. Write AAAA0001, BBBB0002, CCCC0003 back-to-back:
   - wrAck pulses with wrVersion 1, 2, 3.
   - Afterwards versions=16'h3210, slot3 data=CCCC0003, latestVersion=3, wrReady=0, collapsing=1.
3. From test 2, hold readersBusy=1 for 5 cycles → buses unchanged, wrReady=0. Drop readersBusy → 2 cycles later slot0 data=CCCC0003, versions=16'h0000, latestVersion=0, wrReady=1, collapsing=0.
4. Hold wrValid=1 with DDDD0004 throughout DRAIN/COLLAPSE → accepted on the first ACCEPT cycle; wrVersion=1, slot1 data=DDDD0004, versions=16'h0010.
5. Assert rst during DRAIN → next cycle equals the reset state; slot0 data=INIT_DATA; state ACCEPT.
6. readersBusy=1 in ACCEPT with a write of EEEE0005 → accepted normally (wrVersion=1, wrAck=1); busy only gates collapse.
